id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); rst is synchronous and active-high, clock clk.
REQ-002 SHALL have in_valid (in, 1), in_pc (in, 32) and in_pc_next (in, 32): fetch bundle from the fetch stage.
REQ-003 SHALL have in_ready (out, 1): decode accepts the fetch bundle this cycle.
REQ-004 SHALL have imem_resp (in, 1) and imem_rdata (in, 32): instruction word return for the oldest accepted bundle.
REQ-005 SHALL have stall_in (in, 1), asserted when downstream cannot take a decoded instruction, and flush (in, 1), the redirect/kill request.
REQ-006 SHALL have ex_mem_read (in, 1) and ex_rd (in, 5): the load in the execute stage, used for hazard detection.
REQ-007 SHALL have rs1_addr and rs2_addr (out, 5 each) driving the register file read ports.
REQ-008 SHALL have out_valid (out, 1), out_pc and out_pc_next (out, 32 each), out_inst (out, 32), rd_addr (out, 5), funct3 (out, 3), funct7 (out, 7) and imm (out, 32).
REQ-009 SHALL have ctrl outputs (out, 1 each): reg_we, mem_read, mem_write, is_branch, is_jal, is_jalr, alu_imm, illegal; and load_use (out, 1), the hazard indicator.

Function
REQ-010 SHALL implement states IDLE (no instruction), WAIT (bundle latched, word pending), READY (word held) and DRAIN (discard one pending response).
REQ-011 in_ready SHALL be 1 in IDLE and in READY when the held instruction is consumed this cycle (out_valid=1, stall_in=0); otherwise 0.
REQ-012 Accepting a bundle (in_valid & in_ready) SHALL latch in_pc/in_pc_next and enter WAIT, or enter READY directly if imem_resp=1 in the same cycle.
REQ-013 In WAIT, imem_resp=1 SHALL latch imem_rdata and move to READY; otherwise stay in WAIT.
REQ-014 In READY with consumption and no new accept, the state SHALL go to IDLE.
REQ-015 In READY with stall_in=1 or load_use=1, all held registers SHALL be unchanged.
REQ-016 out_valid SHALL be 1 only in READY with load_use=0; when load_use=1 a bubble is emitted (out_valid=0).
REQ-017 load_use SHALL be 1 only in READY with ex_mem_read=1 and ex_rd!=0, where ex_rd equals rs1 of an instruction reading rs1, or rs2 of an R, S or B type instruction.
REQ-018 rs1_addr SHALL be inst[19:15], rs2_addr inst[24:20], rd_addr inst[11:7], funct3 inst[14:12] and funct7 inst[31:25], all taken from the held word and combinational.
REQ-019 imm SHALL be sign-extended from inst[31] for I, S, B, U and J formats; bit 0 SHALL be 0 for B and J; imm[11:0] SHALL be 0 for U; imm SHALL be 0 for R type.
REQ-020 SHALL decode opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP per RV32I; any other opcode SHALL set illegal=1 and reg_we=mem_read=mem_write=0.
REQ-021 reg_we SHALL be forced to 0 when rd_addr=0.
REQ-022 flush SHALL have priority over every other event. flush in IDLE, READY, or in WAIT with imem_resp=1 SHALL go to IDLE. flush in WAIT with imem_resp=0 SHALL go to DRAIN. out_valid SHALL be 0 in the flush cycle.
REQ-023 DRAIN SHALL keep in_ready=0, drop the next imem_resp=1 word unlatched, then return to IDLE; a flush while in DRAIN SHALL remain in DRAIN.
REQ-024 A bundle offered during a flush cycle SHALL NOT be accepted.

Reset
REQ-025 On rst the state SHALL be IDLE; held pc and pc_next SHALL be 0; held inst SHALL be 32'h00000013 (NOP).
REQ-026 During rst, out_valid=0 and load_use=0; in_ready SHALL read 1 in the first cycle after reset.
REQ-027 rst mid-operation, including in WAIT or DRAIN, SHALL abandon the pending response with no further output.

Verification
REQ-028 Bundle pc=0x1eceb000 with imem_resp in the same cycle and rdata=0x00500093 -> next cycle out_valid=1, reg_we=1, rd_addr=1, imm=5, alu_imm=1.
REQ-029 Held inst 0xfe000ee3 (beq x0,x0,-4) -> is_branch=1 and imm=0xfffffffc.
REQ-030 ex_mem_read=1, ex_rd=2, held inst add x3,x2,x1 -> load_use=1, out_valid=0, in_ready=0, inst held; ex_mem_read=0 on the next cycle -> out_valid=1.
REQ-031 flush in WAIT, response arrives 2 cycles later with rdata=0x00100113 -> word dropped, out_valid stays 0, state IDLE, next bundle decodes normally.
REQ-032 stall_in=1 for 3 cycles in READY -> out_pc, out_inst and out_valid=1 stable, in_ready=0; on release, 1-cycle consumption and accept of the next bundle.
REQ-033 Held inst 0x0000007f -> illegal=1, reg_we=0, mem_write=0.

Source files
------------

// File: rtl/id_stage_if.sv
// Fetch-to-decode, instruction-return and decode-output signal bundle.
interface id_stage_if;
  // fetch bundle handshake
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_pc_next;
  logic        in_ready;
  // instruction memory return
  logic        imem_resp;
  logic [31:0] imem_rdata;
  // pipeline control and hazard inputs
  logic        stall_in;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  // register file read addresses
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  // decoded instruction
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_inst;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        reg_we;
  logic        mem_read;
  logic        mem_write;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        alu_imm;
  logic        illegal;
  logic        load_use;

  // fetch / environment side
  modport master (
    output in_valid, in_pc, in_pc_next, imem_resp, imem_rdata,
           stall_in, flush, ex_mem_read, ex_rd,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_pc_next,
           out_inst, rd_addr, funct3, funct7, imm, reg_we, mem_read,
           mem_write, is_branch, is_jal, is_jalr, alu_imm, illegal, load_use
  );

  // decode stage side
  modport slave (
    input  in_valid, in_pc, in_pc_next, imem_resp, imem_rdata,
           stall_in, flush, ex_mem_read, ex_rd,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_pc_next,
           out_inst, rd_addr, funct3, funct7, imm, reg_we, mem_read,
           mem_write, is_branch, is_jal, is_jalr, alu_imm, illegal, load_use
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: holds one fetch bundle, waits for its instruction word,
// decodes it, detects load-use hazards and handles flush/drain of stale returns.
module id_stage (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_next_q, inst_q;
  logic            ld_pc, ld_inst;

  logic            out_valid_c, in_ready_c, consume_c, accept_c;
  logic            load_use_c;

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2, rd;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] imm_c;
  logic            reg_we_raw, mem_read_c, mem_write_c;
  logic            is_branch_c, is_jal_c, is_jalr_c, alu_imm_c, illegal_c;
  logic            uses_rs1, uses_rs2;

  assign opcode = inst_q[6:0];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign rd     = inst_q[11:7];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Held bundle and instruction word; stalls and bubbles simply leave these alone
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      pc_next_q <= '0;
      inst_q    <= NOP;
    end else begin
      if (ld_pc) begin
        pc_q      <= bus.in_pc;
        pc_next_q <= bus.in_pc_next;
      end
      if (ld_inst) inst_q <= bus.imem_rdata;
    end
  end

  // Handshake and next-state; flush outranks every other event
  always_comb begin
    state_d     = state_q;
    ld_pc       = 1'b0;
    ld_inst     = 1'b0;
    out_valid_c = 1'b0;
    consume_c   = 1'b0;
    in_ready_c  = 1'b0;
    accept_c    = 1'b0;

    out_valid_c = (state_q == S_READY) && !load_use_c && !bus.flush && !rst;
    consume_c   = out_valid_c && !bus.stall_in;
    in_ready_c  = !rst && !bus.flush && ((state_q == S_IDLE) || consume_c);
    accept_c    = bus.in_valid && in_ready_c;

    if (bus.flush) begin
      unique case (state_q)
        S_WAIT:  state_d = bus.imem_resp ? S_IDLE : S_DRAIN;
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE, S_READY: begin
          if (accept_c) begin
            ld_pc   = 1'b1;
            ld_inst = bus.imem_resp;
            state_d = bus.imem_resp ? S_READY : S_WAIT;
          end else if (consume_c) begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp) begin
            ld_inst = 1'b1;
            state_d = S_READY;
          end
        end
        S_DRAIN: begin
          // the stale word is discarded, not latched
          if (bus.imem_resp) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Opcode decode into control flags, immediate format and operand usage
  always_comb begin
    imm_sel     = IMM_NONE;
    reg_we_raw  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    is_branch_c = 1'b0;
    is_jal_c    = 1'b0;
    is_jalr_c   = 1'b0;
    alu_imm_c   = 1'b0;
    illegal_c   = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    unique case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_sel    = IMM_U;
        reg_we_raw = 1'b1;
        alu_imm_c  = 1'b1;
      end
      OP_JAL: begin
        imm_sel    = IMM_J;
        reg_we_raw = 1'b1;
        is_jal_c   = 1'b1;
      end
      OP_JALR: begin
        imm_sel    = IMM_I;
        reg_we_raw = 1'b1;
        is_jalr_c  = 1'b1;
        alu_imm_c  = 1'b1;
        uses_rs1   = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel     = IMM_B;
        is_branch_c = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_LOAD: begin
        imm_sel    = IMM_I;
        reg_we_raw = 1'b1;
        mem_read_c = 1'b1;
        alu_imm_c  = 1'b1;
        uses_rs1   = 1'b1;
      end
      OP_STORE: begin
        imm_sel     = IMM_S;
        mem_write_c = 1'b1;
        alu_imm_c   = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_IMM: begin
        imm_sel    = IMM_I;
        reg_we_raw = 1'b1;
        alu_imm_c  = 1'b1;
        uses_rs1   = 1'b1;
      end
      OP_OP: begin
        reg_we_raw = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // Immediate assembly, sign-extended from inst[31]
  always_comb begin
    imm_c = '0;
    unique case (imm_sel)
      IMM_I: imm_c = {{20{inst_q[31]}}, inst_q[31:20]};
      IMM_S: imm_c = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      IMM_B: imm_c = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                      inst_q[11:8], 1'b0};
      IMM_U: imm_c = {inst_q[31:12], 12'h000};
      IMM_J: imm_c = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                      inst_q[30:21], 1'b0};
      default: imm_c = '0;
    endcase
  end

  // Load-use hazard against the load currently in execute
  always_comb begin
    load_use_c = 1'b0;
    if (!rst && state_q == S_READY && bus.ex_mem_read && bus.ex_rd != RW'(0))
      load_use_c = (uses_rs1 && bus.ex_rd == rs1) || (uses_rs2 && bus.ex_rd == rs2);
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.load_use    = load_use_c;
  assign bus.out_pc      = pc_q;
  assign bus.out_pc_next = pc_next_q;
  assign bus.out_inst    = inst_q;
  assign bus.rs1_addr    = rs1;
  assign bus.rs2_addr    = rs2;
  assign bus.rd_addr     = rd;
  assign bus.funct3      = inst_q[14:12];
  assign bus.funct7      = inst_q[31:25];
  assign bus.imm         = imm_c;
  assign bus.reg_we      = reg_we_raw && (rd != RW'(0));
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.is_branch   = is_branch_c;
  assign bus.is_jal      = is_jal_c;
  assign bus.is_jalr     = is_jalr_c;
  assign bus.alu_imm     = alu_imm_c;
  assign bus.illegal     = illegal_c;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, hazards, stalls, flush/drain, reset.
module tb_id_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid    = 1'b0;
    bus.in_pc       = '0;
    bus.in_pc_next  = '0;
    bus.imem_resp   = 1'b0;
    bus.imem_rdata  = '0;
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = '0;
  endtask

  // Offer a bundle whose word returns in the same cycle; ends with it held in READY
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid   = 1'b1;
    bus.in_pc      = pc;
    bus.in_pc_next = pc + 32'd4;
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = inst;
    settle();
    check("offer_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.imem_resp = 1'b0;
    settle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_load_use",  32'(bus.load_use),  32'd0);
    rst = 1'b0;
    settle();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_pc",       bus.out_pc,       32'h0);
    check("post_rst_pc_next",  bus.out_pc_next,  32'h0);
    check("post_rst_inst",     bus.out_inst,     32'h0000_0013);
    check("post_rst_reg_we",   32'(bus.reg_we),  32'd0);

    // addi x1,x0,5 with same-cycle response
    offer(32'h1eceb000, 32'h0050_0093);
    check("addi_out_valid", 32'(bus.out_valid), 32'd1);
    check("addi_reg_we",    32'(bus.reg_we),    32'd1);
    check("addi_rd",        32'(bus.rd_addr),   32'd1);
    check("addi_imm",       bus.imm,            32'd5);
    check("addi_alu_imm",   32'(bus.alu_imm),   32'd1);
    check("addi_pc",        bus.out_pc,         32'h1eceb000);
    check("addi_pc_next",   bus.out_pc_next,    32'h1eceb004);
    check("addi_in_ready",  32'(bus.in_ready),  32'd1);
    step();
    check("addi_idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("addi_idle_in_ready",  32'(bus.in_ready),  32'd1);

    // beq x0,x0,-4 through WAIT
    bus.in_valid   = 1'b1;
    bus.in_pc      = 32'h100;
    bus.in_pc_next = 32'h104;
    step();
    bus.in_valid = 1'b0;
    settle();
    check("wait_out_valid", 32'(bus.out_valid), 32'd0);
    check("wait_in_ready",  32'(bus.in_ready),  32'd0);
    step();
    check("wait_hold_out_valid", 32'(bus.out_valid), 32'd0);
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = 32'hfe00_0ee3;
    step();
    bus.imem_resp = 1'b0;
    settle();
    check("beq_out_valid", 32'(bus.out_valid), 32'd1);
    check("beq_is_branch", 32'(bus.is_branch), 32'd1);
    check("beq_imm",       bus.imm,            32'hffff_fffc);
    check("beq_reg_we",    32'(bus.reg_we),    32'd0);
    check("beq_pc",        bus.out_pc,         32'h100);
    step();

    // add x3,x2,x1 behind a load to x2
    offer(32'h200, 32'h0011_01b3);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd2;
    settle();
    check("lu_load_use", 32'(bus.load_use),  32'd1);
    check("lu_out_valid", 32'(bus.out_valid), 32'd0);
    check("lu_in_ready", 32'(bus.in_ready),  32'd0);
    step();
    check("lu_inst_held", bus.out_inst, 32'h0011_01b3);
    check("lu_rs1",       32'(bus.rs1_addr), 32'd2);
    check("lu_rs2",       32'(bus.rs2_addr), 32'd1);
    bus.ex_rd = 5'd1;
    settle();
    check("lu_rs2_hazard", 32'(bus.load_use), 32'd1);
    bus.ex_mem_read = 1'b0;
    settle();
    check("lu_release_out_valid", 32'(bus.out_valid), 32'd1);
    check("lu_release_load_use",  32'(bus.load_use),  32'd0);
    step();

    // flush in WAIT, stale response two cycles later
    bus.in_valid   = 1'b1;
    bus.in_pc      = 32'h300;
    bus.in_pc_next = 32'h304;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    settle();
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.flush = 1'b0;
    settle();
    check("drain_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = 32'h0010_0113;
    bus.in_valid   = 1'b1;
    bus.in_pc      = 32'h900;
    settle();
    check("drain_resp_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    clear_inputs();
    settle();
    check("drain_done_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_done_in_ready",  32'(bus.in_ready),  32'd1);
    check("drain_word_dropped",   bus.out_inst,       32'h0011_01b3);
    offer(32'h310, 32'h0010_0113);
    check("post_drain_out_valid", 32'(bus.out_valid), 32'd1);
    check("post_drain_rd",        32'(bus.rd_addr),   32'd2);
    check("post_drain_imm",       bus.imm,            32'd1);
    check("post_drain_pc",        bus.out_pc,         32'h310);
    step();

    // three stalled cycles, then consume and accept together
    offer(32'h400, 32'h0050_0093);
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_pc",        bus.out_pc,         32'h400);
      check("stall_inst",      bus.out_inst,       32'h0050_0093);
      check("stall_in_ready",  32'(bus.in_ready),  32'd0);
      step();
    end
    bus.stall_in = 1'b0;
    offer(32'h404, 32'h0000_007f);
    check("ill_out_valid", 32'(bus.out_valid), 32'd1);
    check("ill_pc",        bus.out_pc,         32'h404);
    check("ill_illegal",   32'(bus.illegal),   32'd1);
    check("ill_reg_we",    32'(bus.reg_we),    32'd0);
    check("ill_mem_write", 32'(bus.mem_write), 32'd0);
    check("ill_mem_read",  32'(bus.mem_read),  32'd0);

    // flush in READY kills the instruction
    bus.flush = 1'b1;
    settle();
    check("flush_ready_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    // flush in IDLE must not take the offered bundle
    bus.in_valid   = 1'b1;
    bus.in_pc      = 32'h500;
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    step();
    clear_inputs();
    settle();
    check("flush_idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_idle_in_ready",  32'(bus.in_ready),  32'd1);
    check("flush_idle_pc",        bus.out_pc,         32'h404);

    // lui x4,0x12345
    offer(32'h600, 32'h1234_5237);
    check("lui_imm",     bus.imm,            32'h1234_5000);
    check("lui_reg_we",  32'(bus.reg_we),    32'd1);
    check("lui_rd",      32'(bus.rd_addr),   32'd4);
    step();

    // sw x2,8(x1) and rs2 hazard on a store
    offer(32'h604, 32'h0020_a423);
    check("sw_mem_write", 32'(bus.mem_write), 32'd1);
    check("sw_imm",       bus.imm,            32'd8);
    check("sw_reg_we",    32'(bus.reg_we),    32'd0);
    check("sw_funct3",    32'(bus.funct3),    32'd2);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd2;
    settle();
    check("sw_load_use", 32'(bus.load_use), 32'd1);
    bus.ex_rd = 5'd5;
    settle();
    check("sw_no_hazard", 32'(bus.load_use), 32'd0);
    bus.ex_mem_read = 1'b0;
    step();

    // reset while waiting: pending word must never appear
    bus.in_valid   = 1'b1;
    bus.in_pc      = 32'h700;
    bus.in_pc_next = 32'h704;
    step();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step();
    rst            = 1'b0;
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    settle();
    check("rst_wait_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_wait_pc",       bus.out_pc,        32'h0);
    step();
    bus.imem_resp = 1'b0;
    settle();
    check("rst_wait_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_wait_inst",      bus.out_inst,       32'h0000_0013);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
